acc_register_bank: RTL
======================

// Module: acc_register_bank
// PURPOSE
//  Multi-channel accumulator register bank. Successor to the fixed 8-bit register and 2-bit adder pair.
//  Holds NR_OF_CH accumulators, each NR_OF_BITS wide, with a per-channel carry flag.
//  Applies one op per accepted cycle: load, add, subtract, invert-load, clear or increment.
//  Sits between the ui_in/uio_in pin decode and the uo_out/uio_out drivers of the project top.
// PARAMETERS
//  NR_OF_BITS   8  accumulator/data width, >=2
//  NR_OF_CH     4  number of accumulator channels, power of 2, >=2
//  CH_W         $clog2(NR_OF_CH)  derived localparam: channel index width
// PORTS
//  s_clock      in   1           clock; all state updates on posedge
//  reset        in   1           asynchronous, active-high; clears all state
//  tick         in   1           global enable qualifier; ops are accepted only while high
//  op_valid     in   1           op request
//  op_code      in   3           operation, see BEHAVIOUR
//  op_ch        in   CH_W        target channel
//  op_data      in   NR_OF_BITS  operand
//  op_cin       in   1           carry-in for ADD/SUB
//  rd_ch        in   CH_W        read-port channel select
//  rd_data      out  NR_OF_BITS  accumulator[rd_ch], combinational
//  rd_flags     out  2           {carry[rd_ch], zero[rd_ch]}, combinational
//  res_valid    out  1           one-cycle pulse; the previous cycle's op was applied
//  res_data     out  NR_OF_BITS  new accumulator value from that op
//  res_carry    out  1           new carry value from that op
// BEHAVIOUR
//  Accept: op_valid & tick at posedge s_clock. Otherwise no state change and res_valid=0 next cycle.
//  Ops (acc=acc[op_ch], d=op_data):
//   000 NOP:  no change; res_valid=0
//   001 LOAD: acc<=d; c<=0
//   010 ADD:  {c,acc}<=acc+d+op_cin
//   011 SUB:  {c,acc}<=acc+~d+op_cin. With op_cin=1 this is a true subtract; c=1 means no borrow.
//   100 INV:  acc<=~d; c<=0
//   101 CLR:  acc<=0; c<=0
//   110 INC:  {c,acc}<=acc+1
//   111:      reserved, treated as NOP
//  Latency: one cycle. Accumulator and res_* are registered on the same edge.
//   res_valid is high for exactly one cycle per applied op.
//   Back-to-back ops, including repeated ops on one channel, run at full rate. Each op sees the prior op's result.
//  Width/wrap: arithmetic is modulo 2^NR_OF_BITS, and carry captures bit NR_OF_BITS. Example: 0xFF+1 -> 0x00, c=1.
//  Zero flag: combinational (acc==0), not stored.
//  Read-during-write: rd_data shows the pre-edge value until the posedge, then the new value. No bypass.
//  Reset (including mid-operation): every acc=0, every c=0, res_valid=0, res_data=0, res_carry=0.
//   An op in flight is dropped. Reset has priority over tick.
// CONFIGURATION
//  ACC_SATURATE_EN defined:
//   ADD/INC clamp to all-ones on carry-out.
//   SUB clamps to 0 on borrow (c=0).
//   c still reports the raw carry/borrow.
//  ACC_SATURATE_EN undefined: modular wrap as above. No saturation logic is synthesised.
// STRUCTURE
//  Package acc_pkg:
//   op code constants OP_NOP..OP_INC
//   flag index constants FLAG_ZERO=0, FLAG_CARRY=1
//  Sub-module acc_alu: combinational, NR_OF_BITS parameter.
//   Inputs: acc, d, cin, op_code. Outputs: next_acc, next_c. Holds the saturation logic.
//  Top-level: acc/carry register arrays, accept logic, result register, read mux.
// TESTING
//  1 Reset, then read each rd_ch -> rd_data=0x00, rd_flags=2'b01; res_valid=0.
//  2 LOAD ch2 0xFF, then ADD ch2 d=0x00 cin=1 -> res_data=0x00, res_carry=1;
//    rd_flags[ch2]=2'b11; res_valid one pulse per op.
//  3 LOAD ch0 0x05, then SUB ch0 d=0x07 cin=1 -> 0xFE, c=0; SUB d=0x05 -> 0xF9, c=1.
//  4 op_valid=1, tick=0, LOAD ch1 0xAA -> acc[1] unchanged, res_valid stays 0. Raise tick -> applied.
//  5 INV ch3 d=0x3C -> 0xC3; INC x2 back-to-back -> 0xC4 then 0xC5; CLR -> 0x00, zero=1.
//    Assert reset mid-sequence -> all state 0 immediately.
//  6 ACC_SATURATE_EN build: LOAD 0xF0, ADD 0x20 cin=0 -> 0xFF, c=1.
//    LOAD 0x02, SUB 0x05 cin=1 -> 0x00, c=0.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared definitions for the accumulator register bank: op codes, flag
// positions and a helper that tells whether an op code changes state.
package acc_pkg;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_INV  = 3'b100;
  localparam logic [2:0] OP_CLR  = 3'b101;
  localparam logic [2:0] OP_INC  = 3'b110;
  localparam logic [2:0] OP_RSVD = 3'b111;

  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_CARRY = 1;

  // NOP and the reserved code leave the bank untouched and produce no result
  function automatic logic opApplies(input logic [2:0] code);
    return (code != OP_NOP) && (code != OP_RSVD);
  endfunction

endpackage

// File: rtl/acc_alu.sv
// Combinational datapath for one accumulator op. Computes the next
// accumulator value and carry for the selected op code.
// Build option: define ACC_SATURATE_EN to clamp ADD/INC at all-ones on
// carry-out and SUB at zero on borrow; the carry output always reports the
// raw carry/borrow. Without it, arithmetic wraps modulo 2^NR_OF_BITS.
module acc_alu
  import acc_pkg::*;
#(
  parameter int NR_OF_BITS = 8
) (
  input  logic [NR_OF_BITS-1:0] acc,
  input  logic [NR_OF_BITS-1:0] d,
  input  logic                  cin,
  input  logic [2:0]            op_code,
  output logic [NR_OF_BITS-1:0] next_acc,
  output logic                  next_c
);

  logic [NR_OF_BITS-1:0] operand;
  logic                  carryIn;
  logic [NR_OF_BITS:0]   sum;

  // One shared adder serves ADD, SUB (inverted operand) and INC (zero operand, forced carry-in)
  always_comb begin
    operand = d;
    carryIn = cin;
    case (op_code)
      OP_SUB: operand = ~d;
      OP_INC: begin
        operand = '0;
        carryIn = 1'b1;
      end
      default: ;
    endcase
    sum = {1'b0, acc} + {1'b0, operand} + {{NR_OF_BITS{1'b0}}, carryIn};
  end

  // Select the result for the op; the adder's top bit is the carry
  always_comb begin
    next_acc = acc;
    next_c   = 1'b0;
    case (op_code)
      OP_LOAD: next_acc = d;
      OP_ADD, OP_SUB, OP_INC: begin
        next_acc = sum[NR_OF_BITS-1:0];
        next_c   = sum[NR_OF_BITS];
      end
      OP_INV: next_acc = ~d;
      OP_CLR: next_acc = '0;
      default: ;
    endcase
`ifdef ACC_SATURATE_EN
    if (((op_code == OP_ADD) || (op_code == OP_INC)) && sum[NR_OF_BITS]) begin
      next_acc = '1;
    end else if ((op_code == OP_SUB) && !sum[NR_OF_BITS]) begin
      next_acc = '0;
    end
`endif
  end

endmodule

// File: rtl/acc_register_bank.sv
// Multi-channel accumulator register bank. Holds NR_OF_CH accumulators with
// a carry flag each, applies one op per accepted cycle (op_valid & tick),
// reports the result one cycle later and offers a combinational read port.
// Build option: ACC_SATURATE_EN (see acc_alu) selects saturating arithmetic.
module acc_register_bank
  import acc_pkg::*;
#(
  parameter  int NR_OF_BITS = 8,
  parameter  int NR_OF_CH   = 4,
  localparam int CH_W       = $clog2(NR_OF_CH)
) (
  input  logic                  s_clock,
  input  logic                  reset,
  input  logic                  tick,
  input  logic                  op_valid,
  input  logic [2:0]            op_code,
  input  logic [CH_W-1:0]       op_ch,
  input  logic [NR_OF_BITS-1:0] op_data,
  input  logic                  op_cin,
  input  logic [CH_W-1:0]       rd_ch,
  output logic [NR_OF_BITS-1:0] rd_data,
  output logic [1:0]            rd_flags,
  output logic                  res_valid,
  output logic [NR_OF_BITS-1:0] res_data,
  output logic                  res_carry
);

  logic [NR_OF_BITS-1:0] acc_q [NR_OF_CH];
  logic                  carry_q [NR_OF_CH];
  logic                  res_valid_q;
  logic [NR_OF_BITS-1:0] res_data_q;
  logic                  res_carry_q;

  logic [NR_OF_BITS-1:0] acc_d;
  logic                  carry_d;
  logic                  applyOp;

  // An op only lands when requested, qualified by tick, and not a no-op code
  assign applyOp = op_valid && tick && opApplies(op_code);

  acc_alu #(
    .NR_OF_BITS(NR_OF_BITS)
  ) u_alu (
    .acc     (acc_q[op_ch]),
    .d       (op_data),
    .cin     (op_cin),
    .op_code (op_code),
    .next_acc(acc_d),
    .next_c  (carry_d)
  );

  // Accumulator and carry arrays; only the targeted channel is written
  always_ff @(posedge s_clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NR_OF_CH; i++) begin
        acc_q[i]   <= '0;
        carry_q[i] <= 1'b0;
      end
    end else if (applyOp) begin
      acc_q[op_ch]   <= acc_d;
      carry_q[op_ch] <= carry_d;
    end
  end

  // Result register captures the same value written into the bank, on the same edge
  always_ff @(posedge s_clock or posedge reset) begin
    if (reset) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_carry_q <= 1'b0;
    end else begin
      res_valid_q <= applyOp;
      if (applyOp) begin
        res_data_q  <= acc_d;
        res_carry_q <= carry_d;
      end
    end
  end

  // Read port shows stored state only, so a write becomes visible after its edge
  always_comb begin
    rd_data              = acc_q[rd_ch];
    rd_flags             = '0;
    rd_flags[FLAG_CARRY] = carry_q[rd_ch];
    rd_flags[FLAG_ZERO]  = (acc_q[rd_ch] == '0);
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_carry = res_carry_q;

endmodule
